// File: rtl/wb_mem_line_buffer_if.sv
// Bus bundle for the line buffer: CPU-side (s_*) request/response and
// SPI SRAM controller side (m_*) request/response.
interface wb_mem_line_buffer_if #(
    parameter int ADDR_W = 14
);
    logic              s_cyc;
    logic [ADDR_W-1:0] s_adr;
    logic              s_we;
    logic [31:0]       s_dat_i;
    logic [3:0]        s_sel;
    logic [31:0]       s_dat_o;
    logic              s_ack;

    logic              m_cyc;
    logic [ADDR_W-1:0] m_adr;
    logic              m_we;
    logic [31:0]       m_dat_o;
    logic [3:0]        m_sel;
    logic [31:0]       m_dat_i;
    logic              m_ack;

    // The line buffer itself
    modport slave (
        input  s_cyc, s_adr, s_we, s_dat_i, s_sel, m_dat_i, m_ack,
        output s_dat_o, s_ack, m_cyc, m_adr, m_we, m_dat_o, m_sel
    );

    // The CPU plus SPI SRAM controller surrounding the buffer
    modport master (
        output s_cyc, s_adr, s_we, s_dat_i, s_sel, m_dat_i, m_ack,
        input  s_dat_o, s_ack, m_cyc, m_adr, m_we, m_dat_o, m_sel
    );
endinterface

// File: rtl/wb_mem_line_buffer.sv
// Single-line read buffer in front of the SPI SRAM controller: read hits are
// served locally, misses fill one aligned line, writes go through.
module wb_mem_line_buffer #(
    parameter int ADDR_W     = 14,
    parameter int LINE_WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    wb_mem_line_buffer_if.slave    bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, FILL, FILL_GAP, RESP, WRITE, ACK} state_t;

    state_t             state, state_n;
    logic               valid;
    logic               flush_seen;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   cnt;
    logic [31:0]        line [LINE_WORDS];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               start_fill, start_wr, fill_wr, cnt_inc, fill_done, wr_merge;
    logic [ADDR_W-1:0]  m_adr_n;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    assign idx     = bus.s_adr[IDX_W-1:0];
    assign req_tag = bus.s_adr[ADDR_W-1:IDX_W];
    assign hit     = valid && (tag == req_tag);

    // Hits share the RESP step with completed fills, so a hit acks on the
    // second cycle after the request is first seen.
    always_comb begin
        state_n    = state;
        start_fill = 1'b0;
        start_wr   = 1'b0;
        fill_wr    = 1'b0;
        cnt_inc    = 1'b0;
        fill_done  = 1'b0;
        wr_merge   = 1'b0;
        m_adr_n    = bus.m_adr;
        case (state)
            IDLE: begin
                if (bus.s_cyc) begin
                    if (bus.s_we) begin
                        start_wr = 1'b1;
                        m_adr_n  = bus.s_adr;
                        state_n  = WRITE;
                    end else if (hit) begin
                        state_n = RESP;
                    end else begin
                        start_fill = 1'b1;
                        m_adr_n    = {req_tag, {IDX_W{1'b0}}};
                        state_n    = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.m_ack) begin
                    fill_wr = 1'b1;
                    state_n = FILL_GAP;
                end
            end
            FILL_GAP: begin
                if (cnt == LAST_IDX) begin
                    fill_done = 1'b1;
                    state_n   = RESP;
                end else begin
                    cnt_inc = 1'b1;
                    m_adr_n = {tag, cnt + IDX_W'(1)};
                    state_n = FILL;
                end
            end
            RESP:    state_n = ACK;
            WRITE: begin
                if (bus.m_ack) begin
                    wr_merge = hit;
                    state_n  = ACK;
                end
            end
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            valid       <= 1'b0;
            flush_seen  <= 1'b0;
            tag         <= '0;
            cnt         <= '0;
            bus.s_ack   <= 1'b0;
            bus.s_dat_o <= '0;
            bus.m_cyc   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_adr   <= '0;
            bus.m_dat_o <= '0;
            bus.m_sel   <= 4'h0;
        end else begin
            state     <= state_n;
            bus.s_ack <= (state_n == ACK);
            bus.m_cyc <= (state_n == FILL) || (state_n == WRITE);
            bus.m_adr <= m_adr_n;
            if (start_wr) begin
                bus.m_we    <= 1'b1;
                bus.m_dat_o <= bus.s_dat_i;
                bus.m_sel   <= bus.s_sel;
            end else if (start_fill) begin
                bus.m_we  <= 1'b0;
                bus.m_sel <= 4'hF;
            end
            if (state == RESP)
                bus.s_dat_o <= line[idx];
            if (start_fill) begin
                valid      <= 1'b0;
                tag        <= req_tag;
                cnt        <= '0;
                flush_seen <= i_flush;
            end else begin
                if (cnt_inc)
                    cnt <= cnt + IDX_W'(1);
                if (i_flush)
                    flush_seen <= 1'b1;
            end
            if (fill_done)
                valid <= !(flush_seen || i_flush);
            if (i_flush)
                valid <= 1'b0;
        end
    end

    // Line storage carries no reset; the valid flag guards it.
    always_ff @(posedge clk) begin
        if (fill_wr)
            line[cnt] <= bus.m_dat_i;
        else if (wr_merge)
            line[idx] <= merge_bytes(line[idx], bus.s_dat_i, bus.s_sel);
    end
endmodule

// File: tb/tb_wb_mem_line_buffer.sv
// Scoreboard bench for wb_mem_line_buffer: directed CPU requests, a small SPI
// controller model, and monitors comparing against queued expectations.
module tb_wb_mem_line_buffer;
    localparam int LAT  = 1;
    localparam int MISS = 1 + 4 * (LAT + 2) + 2;
    localparam int HIT  = 3;

    typedef struct {
        logic [13:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } mexp_t;

    typedef struct {
        logic [31:0] dat;
        bit          wr;
        int          lat;
    } sexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic i_flush;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mack_cyc = -10;
    int   req_cnt = 0;
    int   wait_cnt = 0;
    mexp_t mq[$];
    sexp_t sq[$];

    wb_mem_line_buffer_if #(.ADDR_W(14)) bus();

    wb_mem_line_buffer #(.ADDR_W(14), .LINE_WORDS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_flush(i_flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic exp_fill(input logic [13:0] base);
        for (int i = 0; i < 4; i++) begin
            mexp_t e;
            e.adr = base + 14'(i);
            e.we  = 1'b0;
            e.dat = 32'h0;
            e.sel = 4'hF;
            mq.push_back(e);
        end
    endtask

    task automatic exp_wr(input logic [13:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        mexp_t e;
        e.adr = adr;
        e.we  = 1'b1;
        e.dat = dat;
        e.sel = sel;
        mq.push_back(e);
    endtask

    task automatic exp_s(input logic [31:0] dat, input bit wr, input int lat);
        sexp_t e;
        e.dat = dat;
        e.wr  = wr;
        e.lat = lat;
        sq.push_back(e);
    endtask

    task automatic cpu_req(input logic [13:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        bus.s_cyc = 1'b1; bus.s_adr = adr; bus.s_we = we; bus.s_dat_i = dat; bus.s_sel = sel;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.s_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("ack_timeout");
        @(posedge clk); #1;
        bus.s_cyc = 1'b0;
    endtask

    task automatic wait_m_adr(input logic [13:0] adr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.m_cyc && bus.m_adr == adr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Controller model: acks LAT+1 cycles after m_cyc is seen, returns {A5A5, adr}
    initial begin
        mexp_t e;
        bus.m_ack = 1'b0;
        bus.m_dat_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.m_ack = 1'b0;
                wait_cnt = 0;
            end else if (bus.m_ack) begin
                bus.m_ack = 1'b0;
            end else if (bus.m_cyc) begin
                if (wait_cnt == LAT) begin
                    wait_cnt = 0;
                    bus.m_ack = 1'b1;
                    bus.m_dat_i = {16'hA5A5, 2'b00, bus.m_adr};
                    if (mq.size() == 0) begin
                        fail_now("m_unexpected_access");
                    end else begin
                        e = mq.pop_front();
                        check("m_adr", 32'(bus.m_adr), 32'(e.adr));
                        check("m_we", 32'(bus.m_we), 32'(e.we));
                        check("m_sel", 32'(bus.m_sel), 32'(e.sel));
                        if (e.we) check("m_dat_o", bus.m_dat_o, e.dat);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // CPU-side monitor
    initial begin
        sexp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                req_cnt = 0;
            end else begin
                if (bus.m_ack) mack_cyc = cyc;
                if (bus.s_cyc) req_cnt++;
                if (bus.s_ack) begin
                    if (sq.size() == 0) begin
                        fail_now("s_unexpected_ack");
                    end else begin
                        e = sq.pop_front();
                        check("s_dat_o", bus.s_dat_o, e.dat);
                        if (e.wr) check("wr_ack_latency", 32'(cyc - mack_cyc), 32'd1);
                        else      check("rd_ack_latency", 32'(req_cnt), 32'(e.lat));
                    end
                    req_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        i_flush = 1'b0;
        bus.s_cyc = 1'b0; bus.s_adr = '0; bus.s_we = 1'b0; bus.s_dat_i = '0; bus.s_sel = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ack", 32'(bus.s_ack), 32'd0);
        check("rst_m_cyc", 32'(bus.m_cyc), 32'd0);
        check("rst_m_we", 32'(bus.m_we), 32'd0);
        check("rst_s_dat_o", bus.s_dat_o, 32'd0);
        check("rst_m_adr", 32'(bus.m_adr), 32'd0);
        check("rst_m_dat_o", bus.m_dat_o, 32'd0);
        check("rst_m_sel", 32'(bus.m_sel), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        exp_fill(14'h0010); exp_s(32'hA5A50012, 1'b0, MISS);
        cpu_req(14'h0012, 1'b0, 32'h0, 4'hF);
        exp_s(32'hA5A50011, 1'b0, HIT);
        cpu_req(14'h0011, 1'b0, 32'h0, 4'hF);
        exp_wr(14'h0011, 32'h11223344, 4'b0011); exp_s(32'hA5A50011, 1'b1, 0);
        cpu_req(14'h0011, 1'b1, 32'h11223344, 4'b0011);
        exp_s(32'hA5A53344, 1'b0, HIT);
        cpu_req(14'h0011, 1'b0, 32'h0, 4'h1);
        exp_wr(14'h0100, 32'hDEADBEEF, 4'hF); exp_s(32'hA5A53344, 1'b1, 0);
        cpu_req(14'h0100, 1'b1, 32'hDEADBEEF, 4'hF);
        exp_s(32'hA5A50013, 1'b0, HIT);
        cpu_req(14'h0013, 1'b0, 32'h0, 4'hF);

        // Flush pulsed while word 1 of the fill is outstanding
        exp_fill(14'h0020); exp_s(32'hA5A50020, 1'b0, MISS);
        fork
            cpu_req(14'h0020, 1'b0, 32'h0, 4'hF);
            begin
                wait_m_adr(14'h0021, ok);
                if (!ok) fail_now("flush_fill_word1_timeout");
                i_flush = 1'b1;
                @(negedge clk) i_flush = 1'b0;
            end
        join
        exp_fill(14'h0020); exp_s(32'hA5A50021, 1'b0, MISS);
        cpu_req(14'h0021, 1'b0, 32'h0, 4'hF);
        exp_s(32'hA5A50022, 1'b0, HIT);
        cpu_req(14'h0022, 1'b0, 32'h0, 4'hF);

        // Flush coincident with a hit: served from the line, then invalid
        exp_s(32'hA5A50023, 1'b0, HIT);
        fork
            cpu_req(14'h0023, 1'b0, 32'h0, 4'hF);
            begin
                @(posedge clk); #1 i_flush = 1'b1;
                @(posedge clk); #1 i_flush = 1'b0;
            end
        join
        exp_fill(14'h0020); exp_s(32'hA5A50023, 1'b0, MISS);
        cpu_req(14'h0023, 1'b0, 32'h0, 4'hF);

        // Top line of the address range
        exp_fill(14'h3FFC); exp_s(32'hA5A53FFE, 1'b0, MISS);
        cpu_req(14'h3FFE, 1'b0, 32'h0, 4'hF);
        exp_s(32'hA5A53FFF, 1'b0, HIT);
        cpu_req(14'h3FFF, 1'b0, 32'h0, 4'hF);

        // Reset while word 2 of a fill is outstanding
        exp_fill(14'h0010);
        @(posedge clk); #1;
        bus.s_cyc = 1'b1; bus.s_adr = 14'h0012; bus.s_we = 1'b0; bus.s_sel = 4'hF;
        wait_m_adr(14'h0012, ok);
        if (!ok) fail_now("reset_fill_word2_timeout");
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_cyc", 32'(bus.m_cyc), 32'd0);
        check("rst_mid_s_ack", 32'(bus.s_ack), 32'd0);
        check("rst_mid_m_adr", 32'(bus.m_adr), 32'd0);
        bus.s_cyc = 1'b0;
        mq.delete();
        sq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        exp_fill(14'h0010); exp_s(32'hA5A50012, 1'b0, MISS);
        cpu_req(14'h0012, 1'b0, 32'h0, 4'hF);

        repeat (5) @(negedge clk);
        check("m_queue_drained", 32'(mq.size()), 32'd0);
        check("s_queue_drained", 32'(sq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
